forward_lookup_arbiter: RTL and testbench

Shares the single MAC address table lookup port among all ingress ports of the forwarding path. Each cycle it picks one eligible ingress port round-robin and issues its header fields as a lookup. It tracks every in-flight lookup in a tag FIFO so each fixed-latency table result is returned tagged with its source port and VLAN. It sits between the per-port ingress state and the MAC address table, and feeds per-port "lookup done" results to the forwarding decision logic.

---
 rtl/forward_lookup_arbiter_if.sv | 43 ++++
 rtl/forward_lookup_arbiter.sv | 131 +++++++++++++
 tb/tb_forward_lookup_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/forward_lookup_arbiter_if.sv
// forward_lookup_arbiter_if: request, table-lookup and response bundle of the
// forward lookup arbiter. The master side is the arbiter; the slave side is
// the ingress ports, the MAC table and the forwarding decision logic.
interface forward_lookup_arbiter_if #(
  parameter int NUM_PORTS = 15,
  parameter int PORT_BITS = $clog2(NUM_PORTS)
) ();
  logic [NUM_PORTS-1:0]       req_valid;
  logic [NUM_PORTS-1:0][11:0] req_src_vlan;
  logic [NUM_PORTS-1:0][47:0] req_src_mac;
  logic [NUM_PORTS-1:0][47:0] req_dst_mac;
  logic [NUM_PORTS-1:0]       req_grant;

  logic                 lookup_en;
  logic [11:0]          lookup_src_vlan;
  logic [47:0]          lookup_src_mac;
  logic [PORT_BITS-1:0] lookup_src_port;
  logic [47:0]          lookup_dst_mac;
  logic                 lookup_hit;
  logic [PORT_BITS-1:0] lookup_dst_port;

  logic                 rsp_valid;
  logic [PORT_BITS-1:0] rsp_port;
  logic                 rsp_hit;
  logic [PORT_BITS-1:0] rsp_dst_port;
  logic [11:0]          rsp_vlan;

  modport master (
    input  req_valid, req_src_vlan, req_src_mac, req_dst_mac,
    input  lookup_hit, lookup_dst_port,
    output req_grant,
    output lookup_en, lookup_src_vlan, lookup_src_mac, lookup_src_port, lookup_dst_mac,
    output rsp_valid, rsp_port, rsp_hit, rsp_dst_port, rsp_vlan
  );

  modport slave (
    output req_valid, req_src_vlan, req_src_mac, req_dst_mac,
    output lookup_hit, lookup_dst_port,
    input  req_grant,
    input  lookup_en, lookup_src_vlan, lookup_src_mac, lookup_src_port, lookup_dst_mac,
    input  rsp_valid, rsp_port, rsp_hit, rsp_dst_port, rsp_vlan
  );
endinterface

// File: rtl/forward_lookup_arbiter.sv
// forward_lookup_arbiter: round-robin sharing of the single MAC table lookup
// port among the ingress ports. Each issued lookup leaves a {port, vlan} tag
// in a FIFO; a valid shift register matched to the table latency marks the
// cycle its result arrives, and the result leaves tagged with that entry.
// Optional lookup/miss counters are built when FORWARD_LOOKUP_STATS_EN is
// defined; otherwise the stat ports read 0.
module forward_lookup_arbiter #(
  parameter int NUM_PORTS      = 15,
  parameter int LOOKUP_LATENCY = 4,
  parameter int TAG_DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  forward_lookup_arbiter_if.master bus,
  input  logic                     pause,
  output logic                     lookup_busy,
  output logic [31:0]              stat_lookups,
  output logic [31:0]              stat_misses
);
  localparam int PORT_BITS = $clog2(NUM_PORTS);
  localparam int PTR_BITS  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_BITS  = $clog2(TAG_DEPTH + 1);

  logic [NUM_PORTS-1:0]      pending, pending_nxt, eligible, pop_mask;
  logic [PORT_BITS-1:0]      rr_ptr, win_idx;
  logic                      win_found, do_grant, do_pop;
  logic [LOOKUP_LATENCY-1:0] vld_sr;
  logic [CNT_BITS-1:0]       inflight, inflight_nxt;
  logic [PTR_BITS-1:0]       wr_ptr, rd_ptr;
  logic [PORT_BITS-1:0]      tag_port [TAG_DEPTH];
  logic [11:0]               tag_vlan [TAG_DEPTH];

  assign eligible = bus.req_valid & ~pending;
  assign do_pop   = vld_sr[LOOKUP_LATENCY-1];
  assign do_grant = win_found & ~pause & (inflight != CNT_BITS'(TAG_DEPTH));

  // First eligible port at or after rr_ptr, wrapping at NUM_PORTS (not a power of two).
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!win_found && eligible[PORT_BITS'(cand)]) begin
        win_found = 1'b1;
        win_idx   = PORT_BITS'(cand);
      end
    end
  end

  // Next pending set and in-flight count; a pop frees its port for the same edge's arbitration result.
  always_comb begin
    pop_mask    = do_pop ? (NUM_PORTS'(1) << tag_port[rd_ptr]) : '0;
    pending_nxt = pending & ~pop_mask;
    if (do_grant) pending_nxt = pending_nxt | (NUM_PORTS'(1) << win_idx);
    inflight_nxt = inflight;
    if (do_grant && !do_pop)      inflight_nxt = inflight + 1'b1;
    else if (!do_grant && do_pop) inflight_nxt = inflight - 1'b1;
  end

  // Tag storage needs no reset; only the pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (do_grant) begin
      tag_port[wr_ptr] <= win_idx;
      tag_vlan[wr_ptr] <= bus.req_src_vlan[win_idx];
    end
  end

  // Issue, tracking and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.lookup_en       <= 1'b0;
      bus.req_grant       <= '0;
      bus.lookup_src_vlan <= '0;
      bus.lookup_src_mac  <= '0;
      bus.lookup_src_port <= '0;
      bus.lookup_dst_mac  <= '0;
      bus.rsp_valid       <= 1'b0;
      bus.rsp_port        <= '0;
      bus.rsp_hit         <= 1'b0;
      bus.rsp_dst_port    <= '0;
      bus.rsp_vlan        <= '0;
      lookup_busy         <= 1'b0;
      pending             <= '0;
      rr_ptr              <= '0;
      vld_sr              <= '0;
      inflight            <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
    end else begin
      bus.lookup_en       <= do_grant;
      bus.req_grant       <= do_grant ? (NUM_PORTS'(1) << win_idx) : '0;
      bus.lookup_src_vlan <= do_grant ? bus.req_src_vlan[win_idx] : '0;
      bus.lookup_src_mac  <= do_grant ? bus.req_src_mac[win_idx] : '0;
      bus.lookup_src_port <= do_grant ? win_idx : '0;
      bus.lookup_dst_mac  <= do_grant ? bus.req_dst_mac[win_idx] : '0;
      if (do_grant) begin
        rr_ptr <= (win_idx == PORT_BITS'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
        wr_ptr <= (wr_ptr == PTR_BITS'(TAG_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      bus.rsp_valid    <= do_pop;
      bus.rsp_port     <= do_pop ? tag_port[rd_ptr] : '0;
      bus.rsp_vlan     <= do_pop ? tag_vlan[rd_ptr] : '0;
      bus.rsp_hit      <= do_pop & bus.lookup_hit;
      bus.rsp_dst_port <= do_pop ? bus.lookup_dst_port : '0;
      if (do_pop) rd_ptr <= (rd_ptr == PTR_BITS'(TAG_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      vld_sr      <= LOOKUP_LATENCY'({vld_sr, bus.lookup_en});
      pending     <= pending_nxt;
      inflight    <= inflight_nxt;
      lookup_busy <= (|pending_nxt) | (inflight_nxt != '0);
    end
  end

`ifdef FORWARD_LOOKUP_STATS_EN
  // Saturating lookup and miss counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups <= '0;
      stat_misses  <= '0;
    end else begin
      if (do_grant && stat_lookups != '1) stat_lookups <= stat_lookups + 1'b1;
      if (do_pop && !bus.lookup_hit && stat_misses != '1) stat_misses <= stat_misses + 1'b1;
    end
  end
`else
  assign stat_lookups = '0;
  assign stat_misses  = '0;
`endif
endmodule

// File: tb/tb_forward_lookup_arbiter.sv
// tb_forward_lookup_arbiter: directed scenarios plus a randomized run, every
// cycle checked against a queue-based reference of the arbiter's behaviour.
module tb_forward_lookup_arbiter;
  localparam int N   = 15;
  localparam int LAT = 4;
  localparam int TD  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pause;
  logic lookup_busy;
  logic [31:0] stat_lookups, stat_misses;

  forward_lookup_arbiter_if #(.NUM_PORTS(N)) bus ();

  forward_lookup_arbiter #(.NUM_PORTS(N), .LOOKUP_LATENCY(LAT), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pause(pause), .lookup_busy(lookup_busy),
    .stat_lookups(stat_lookups), .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus state
  logic [N-1:0] want;
  logic [11:0]  fr_vlan [N];
  logic [47:0]  fr_smac [N];
  logic [47:0]  fr_dmac [N];
  bit           tbl_fixed;
  bit           tbl_hit;
  int           tbl_dst;
  bit           drv_hit;
  int           drv_dst;
  bit           pause_drv;

  // reference model
  typedef struct { int port; logic [11:0] vlan; int due; } ent_t;
  ent_t m_q[$];
  bit   m_pend [N];
  int   m_rr, m_cyc, m_lookups, m_misses;

  logic        e_en, e_rv, e_rhit, e_busy;
  logic [N-1:0] e_grant;
  logic [11:0] e_vlan, e_rvlan;
  logic [47:0] e_smac, e_dmac;
  int          e_sport, e_rport, e_rdst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, m_cyc, act, exp);
    end
  endtask

  task automatic clear_exp();
    e_en = 0; e_grant = '0; e_vlan = '0; e_smac = '0; e_dmac = '0; e_sport = 0;
    e_rv = 0; e_rport = 0; e_rhit = 0; e_rdst = 0; e_rvlan = '0; e_busy = 0;
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int p = 0; p < N; p++) m_pend[p] = 0;
    m_rr = 0; m_cyc = 0; m_lookups = 0; m_misses = 0;
    clear_exp();
  endtask

  // One clock edge of the reference: arbitration on pre-edge state, result pop, issue push.
  task automatic model_edge();
    int win;
    bit full;
    ent_t ent;
    clear_exp();
    full = (m_q.size() == TD);
    win  = -1;
    if (!pause_drv && !full)
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_rr + k) % N;
        if (win < 0 && want[p] && !m_pend[p]) win = p;
      end
    if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
      ent = m_q.pop_front();
      e_rv = 1; e_rport = ent.port; e_rvlan = ent.vlan; e_rhit = drv_hit; e_rdst = drv_dst;
      m_pend[ent.port] = 0;
      if (!drv_hit) m_misses++;
    end
    if (win >= 0) begin
      e_en = 1; e_grant = N'(1) << win; e_sport = win;
      e_vlan = fr_vlan[win]; e_smac = fr_smac[win]; e_dmac = fr_dmac[win];
      m_pend[win] = 1;
      m_rr = (win + 1) % N;
      ent.port = win; ent.vlan = fr_vlan[win]; ent.due = m_cyc + 1 + LAT;
      m_q.push_back(ent);
      m_lookups++;
    end
    e_busy = (m_q.size() != 0);
    for (int p = 0; p < N; p++) if (m_pend[p]) e_busy = 1;
    m_cyc++;
  endtask

  task automatic compare();
    chk("lookup_en", bus.lookup_en, e_en);
    chk("req_grant", bus.req_grant, e_grant);
    chk("lookup_src_vlan", bus.lookup_src_vlan, e_vlan);
    chk("lookup_src_mac", bus.lookup_src_mac, e_smac);
    chk("lookup_src_port", bus.lookup_src_port, e_sport);
    chk("lookup_dst_mac", bus.lookup_dst_mac, e_dmac);
    chk("rsp_valid", bus.rsp_valid, e_rv);
    chk("rsp_port", bus.rsp_port, e_rport);
    chk("rsp_hit", bus.rsp_hit, e_rhit);
    chk("rsp_dst_port", bus.rsp_dst_port, e_rdst);
    chk("rsp_vlan", bus.rsp_vlan, e_rvlan);
    chk("lookup_busy", lookup_busy, e_busy);
`ifdef FORWARD_LOOKUP_STATS_EN
    chk("stat_lookups", stat_lookups, m_lookups);
    chk("stat_misses", stat_misses, m_misses);
`else
    chk("stat_lookups", stat_lookups, 0);
    chk("stat_misses", stat_misses, 0);
`endif
  endtask

  task automatic set_frame(input int p, input logic [11:0] vlan);
    fr_vlan[p] = vlan;
    fr_smac[p] = 48'({$urandom(), $urandom()});
    fr_dmac[p] = 48'({$urandom(), $urandom()});
    want[p] = 1'b1;
  endtask

  // Drive one cycle of inputs, advance the model, check after the edge, apply the requester contract.
  task automatic step();
    drv_hit = tbl_fixed ? tbl_hit : bit'($urandom_range(1, 0));
    drv_dst = tbl_fixed ? tbl_dst : int'($urandom_range(N - 1, 0));
    bus.req_valid = want;
    for (int p = 0; p < N; p++) begin
      bus.req_src_vlan[p] = fr_vlan[p];
      bus.req_src_mac[p]  = fr_smac[p];
      bus.req_dst_mac[p]  = fr_dmac[p];
    end
    bus.lookup_hit      = drv_hit;
    bus.lookup_dst_port = 4'(drv_dst);
    pause = pause_drv;
    model_edge();
    @(posedge clk);
    #1;
    compare();
    if (e_rv) want[e_rport] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    want = '0;
    pause_drv = 0;
    #2;
    model_reset();
    compare();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int rsp_cnt;

  initial begin
    want = '0; pause_drv = 0; pause = 0; tbl_fixed = 0; tbl_hit = 0; tbl_dst = 0;
    drv_hit = 0; drv_dst = 0;
    for (int p = 0; p < N; p++) begin
      fr_vlan[p] = '0; fr_smac[p] = '0; fr_dmac[p] = '0;
    end
    bus.req_valid = '0; bus.lookup_hit = 0; bus.lookup_dst_port = '0;
    bus.req_src_vlan = '0; bus.req_src_mac = '0; bus.req_dst_mac = '0;
    #1;
    do_reset();
    chk("reset_busy", lookup_busy, 0);
    chk("reset_en", bus.lookup_en, 0);

    // single request on port 3, table answers hit to port 7
    tbl_fixed = 1; tbl_hit = 1; tbl_dst = 7;
    set_frame(3, 12'd5);
    step();
    chk("single_en", bus.lookup_en, 1);
    chk("single_grant", bus.req_grant, 15'h0008);
    chk("single_port", bus.lookup_src_port, 3);
    repeat (4) begin
      step();
      chk("single_rsp_early", bus.rsp_valid, 0);
    end
    step();
    chk("single_rsp_valid", bus.rsp_valid, 1);
    chk("single_rsp_port", bus.rsp_port, 3);
    chk("single_rsp_hit", bus.rsp_hit, 1);
    chk("single_rsp_dst", bus.rsp_dst_port, 7);
    chk("single_rsp_vlan", bus.rsp_vlan, 5);
    chk("single_busy_clear", lookup_busy, 0);
    tbl_fixed = 0;

    // full load from reset
    do_reset();
    for (int p = 0; p < N; p++) set_frame(p, 12'($urandom));
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c <= 15) chk("full_grant", bus.req_grant, N'(1) << (c - 1));
      else chk("full_idle", bus.lookup_en, 0);
      if (c >= 6) begin
        chk("full_rsp_valid", bus.rsp_valid, 1);
        chk("full_rsp_port", bus.rsp_port, c - 6);
      end
    end
    step();
    for (int p = 0; p < N; p++) set_frame(p, 12'($urandom));
    step();
    chk("full_next_port0", bus.req_grant, 15'h0001);
    repeat (30) step();

    // round-robin wrap: rr_ptr=13, eligible {2,14}
    do_reset();
    set_frame(12, 12'd1);
    step();
    chk("wrap_g12", bus.req_grant, 15'h1000);
    set_frame(2, 12'd2); set_frame(14, 12'd3);
    step();
    chk("wrap_g14", bus.req_grant, 15'h4000);
    step();
    chk("wrap_g2", bus.req_grant, 15'h0004);
    set_frame(1, 12'd4); set_frame(3, 12'd5);
    step();
    chk("wrap_rr3", bus.req_grant, 15'h0008);
    step();
    chk("wrap_g1", bus.req_grant, 15'h0002);
    repeat (10) step();

    // pause with three lookups in flight
    do_reset();
    set_frame(0, 12'd10); set_frame(1, 12'd11); set_frame(2, 12'd12);
    repeat (3) step();
    chk("pause_third_grant", bus.req_grant, 15'h0004);
    pause_drv = 1;
    set_frame(4, 12'd14); set_frame(5, 12'd15);
    rsp_cnt = 0;
    for (int c = 4; c <= 7; c++) begin
      step();
      chk("pause_no_en", bus.lookup_en, 0);
      chk("pause_busy", lookup_busy, 1);
      if (bus.rsp_valid) rsp_cnt++;
    end
    pause_drv = 0;
    step();
    if (bus.rsp_valid) rsp_cnt++;
    chk("pause_rsp_count", rsp_cnt, 3);
    chk("pause_resume", bus.req_grant, 15'h0010);
    repeat (12) step();

    // reset while a lookup is in flight; late table hits must be ignored
    do_reset();
    set_frame(6, 12'd9);
    step();
    chk("rstflt_en", bus.lookup_en, 1);
    repeat (2) step();
    do_reset();
    chk("rstflt_rsp", bus.rsp_valid, 0);
    chk("rstflt_grant", bus.req_grant, 0);
    chk("rstflt_busy", lookup_busy, 0);
    tbl_fixed = 1; tbl_hit = 1; tbl_dst = 2;
    repeat (6) begin
      step();
      chk("rstflt_no_rsp", bus.rsp_valid, 0);
      chk("rstflt_idle", lookup_busy, 0);
    end

    // stats: four lookups, one miss
    do_reset();
    for (int p = 0; p < 4; p++) set_frame(p, 12'(p));
    for (int c = 0; c <= 9; c++) begin
      tbl_hit = (c != 6);
      step();
    end
`ifdef FORWARD_LOOKUP_STATS_EN
    chk("stats_lookups", stat_lookups, 4);
    chk("stats_misses", stat_misses, 1);
`else
    chk("stats_lookups_off", stat_lookups, 0);
    chk("stats_misses_off", stat_misses, 0);
`endif
    tbl_fixed = 0;

    // randomized traffic with pause bursts and occasional reset
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < N; p++)
        if (!want[p] && !m_pend[p] && $urandom_range(2, 0) == 0) set_frame(p, 12'($urandom));
      if ($urandom_range(15, 0) == 0) pause_drv = !pause_drv;
      if ($urandom_range(999, 0) == 0) do_reset();
      else step();
    end
    pause_drv = 0;
    want = '0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
